pwm_deadtime: RTL
=================

Name: pwm_deadtime

Overview:
- Three-phase dead-time insertion and gate-drive safety stage, directly downstream of the motor-control top.
- Consumes the single-ended pwmA_out/pwmB_out/pwmC_out commands and produces complementary high-side/low-side gate signals.
- Guarantees a programmable interval in which both switches of a leg are off between commutations.
- Provides a latched fault shutdown that forces every gate off.

Parameters:
- DT_WIDTH, 8, width of the dead-time count in clk cycles.
- PHASES, 3, number of half-bridge legs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  gate-drive enable; 0 forces all gates off
- pwm_in  in  PHASES  PWM command per phase (bit0=A, bit1=B, bit2=C); 1 requests high side on
- dead_cycles  in  DT_WIDTH  dead time in clk cycles; 0 is treated as 1
- fault_in  in  1  external fault (overcurrent/desat), active high
- fault_clr  in  1  single-cycle fault acknowledge
- gate_hi  out  PHASES  high-side gate drive
- gate_lo  out  PHASES  low-side gate drive
- fault_latched  out  1  sticky fault status

Behaviour:
- Reset: asynchronous, active-high. All phases go to OFF; gate_hi=0, gate_lo=0, fault_latched=0, counters=0.
- All outputs are registered and decoded from the next state:
  - gate_hi = (state==HI)
  - gate_lo = (state==LO)
- Per-phase states: OFF, LO, DEAD_H, HI, DEAD_L. gate_hi and gate_lo are never both 1 in any cycle.
- kill = !enable | fault_latched | fault_in. When kill is true, every phase goes to OFF at the next edge, from any state.
- OFF, kill=0:
  - pwm_in=0 -> LO
  - pwm_in=1 -> DEAD_H, cnt<=max(dead_cycles,1)
- LO: pwm_in=1 -> DEAD_H, cnt<=max(dead_cycles,1).
- DEAD_H:
  - pwm_in=0 -> LO. The pulse is swallowed; the high side never turned on.
  - else cnt==1 -> HI.
  - else cnt<=cnt-1.
- HI: pwm_in=0 -> DEAD_L, cnt<=max(dead_cycles,1).
- DEAD_L: mirror of DEAD_H (pwm_in=1 -> HI; cnt==1 -> LO).
- Timing, for dead_cycles=D≥1 and pwm_in rising before edge k:
  - gate_lo falls at edge k.
  - gate_hi rises at edge k+D.
  - Both gates are low for exactly D cycles. The falling transition is symmetric.
- dead_cycles is sampled only on entry to a DEAD state. Changes during an interval take effect at the next commutation.
- Fault latch:
  - fault_in=1 at an edge -> fault_latched<=1, and all gates are 0 after that same edge.
  - fault_clr=1 with fault_in=0 -> fault_latched<=0.
  - fault_clr and fault_in both 1 -> latch stays set.
  - After clear, phases leave OFF per the OFF rules above.
- No arithmetic beyond the down-counter. The counter never wraps: it is loaded with ≥1 and leaves the DEAD state at 1.
- Phases are fully independent. Simultaneous edges on several pwm_in bits are each handled in the same cycle.

Decomposition:
- Shared package (motor-control package):
  - phase state enum {OFF, LO, DEAD_H, HI, DEAD_L}
  - DT_WIDTH default constant
- Sub-module deadtime_phase: one-leg FSM plus counter, with inputs pwm, dead_cycles, kill.
- The top instantiates PHASES copies with a generate loop and holds the shared fault latch and kill logic.

Test Plan:
- Reset: assert rst mid-operation with gate_hi[0]=1 -> all gates 0 and fault_latched=0 immediately, without waiting for a clock edge.
- Dead time, enable=1, dead_cycles=4:
  - pwm_in[0] 0->1 -> gate_lo[0] falls 1 edge later, gate_hi[0] rises exactly 4 cycles after that.
  - pwm_in[0] 1->0 -> gate_hi[0] falls, gate_lo[0] rises 4 cycles later.
  - A checker asserts that gate_hi and gate_lo are never both high.
- Narrow pulse, dead_cycles=5: pwm_in[1] high for 2 cycles -> gate_hi[1] never asserts; gate_lo[1] re-asserts at the first edge that sees pwm_in[1]=0.
- Zero dead time: dead_cycles=0, toggle pwm_in[2] -> a 1-cycle both-low gap on each transition.
- Mid-interval change: set dead_cycles=8, enter DEAD_H, change dead_cycles to 2 -> the current gap is still 8 cycles; the next commutation uses 2.
- Fault sequence:
  - fault_in pulse while phase A is HI -> all gates 0 next edge, fault_latched=1.
  - fault_clr while fault_in=1 -> latch remains set.
  - fault_clr after fault_in drops -> latch clears; with pwm_in=0 the phases re-enter LO, and with pwm_in=1 they pass through DEAD_H before HI.

Source files
------------

// File: rtl/pwm_deadtime_pkg.sv
// Shared motor-control definitions for the dead-time / gate-drive stage:
// per-leg state encoding and default widths.
package pwm_deadtime_pkg;

  localparam int DT_WIDTH_DEF = 8;
  localparam int PHASES_DEF   = 3;

  typedef enum logic [2:0] {
    PH_OFF    = 3'd0,
    PH_LO     = 3'd1,
    PH_DEAD_H = 3'd2,
    PH_HI     = 3'd3,
    PH_DEAD_L = 3'd4
  } phase_state_t;

endpackage

// File: rtl/pwm_deadtime_phase.sv
// One half-bridge leg: dead-time FSM with a down-counter.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   PH_OFF    | both switches off (reset, disable or fault)
//   PH_LO     | low-side switch on
//   PH_DEAD_H | both off, counting down before turning the high side on
//   PH_HI     | high-side switch on
//   PH_DEAD_L | both off, counting down before turning the low side on
//
// Gate outputs are registered and set together with the state they belong
// to, so they always reflect the state entered at the same edge.
module pwm_deadtime_phase
  import pwm_deadtime_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm,
  input  logic [DT_WIDTH-1:0] dead_cycles,
  input  logic                kill,
  output logic                gate_hi,
  output logic                gate_lo
);

  localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

  phase_state_t        r_state;
  logic [DT_WIDTH-1:0] r_cnt;
  logic                r_gate_hi;
  logic                r_gate_lo;
  logic [DT_WIDTH-1:0] w_load;

  // A programmed dead time of zero still gives one full both-off cycle;
  // this also keeps the counter from ever being loaded with zero.
  assign w_load = (dead_cycles == '0) ? CNT_ONE : dead_cycles;

  // Leg FSM, counter and gate registers; kill overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= PH_OFF;
      r_cnt     <= '0;
      r_gate_hi <= 1'b0;
      r_gate_lo <= 1'b0;
    end else begin
      r_gate_hi <= 1'b0;
      r_gate_lo <= 1'b0;
      if (kill) begin
        r_state <= PH_OFF;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          PH_OFF: begin
            if (pwm) begin
              r_state <= PH_DEAD_H;
              r_cnt   <= w_load;
            end else begin
              r_state   <= PH_LO;
              r_gate_lo <= 1'b1;
            end
          end
          PH_LO: begin
            if (pwm) begin
              r_state <= PH_DEAD_H;
              r_cnt   <= w_load;
            end else begin
              r_gate_lo <= 1'b1;
            end
          end
          PH_DEAD_H: begin
            // A command that drops before the interval ends is swallowed.
            if (!pwm) begin
              r_state   <= PH_LO;
              r_gate_lo <= 1'b1;
            end else if (r_cnt == CNT_ONE) begin
              r_state   <= PH_HI;
              r_gate_hi <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          PH_HI: begin
            if (!pwm) begin
              r_state <= PH_DEAD_L;
              r_cnt   <= w_load;
            end else begin
              r_gate_hi <= 1'b1;
            end
          end
          PH_DEAD_L: begin
            if (pwm) begin
              r_state   <= PH_HI;
              r_gate_hi <= 1'b1;
            end else if (r_cnt == CNT_ONE) begin
              r_state   <= PH_LO;
              r_gate_lo <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          default: begin
            r_state <= PH_OFF;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign gate_hi = r_gate_hi;
  assign gate_lo = r_gate_lo;

endmodule

// File: rtl/pwm_deadtime.sv
// Three-phase dead-time insertion and gate-drive safety stage.
// Holds the sticky fault latch and the shared kill term; each leg is an
// independent pwm_deadtime_phase instance.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF,
  parameter int PHASES   = PHASES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PHASES-1:0]   pwm_in,
  input  logic [DT_WIDTH-1:0] dead_cycles,
  input  logic                fault_in,
  input  logic                fault_clr,
  output logic [PHASES-1:0]   gate_hi,
  output logic [PHASES-1:0]   gate_lo,
  output logic                fault_latched
);

  logic r_fault_latched;
  logic w_kill;

  // Sticky fault: a set request always wins over an acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_latched <= 1'b0;
    end else if (fault_in) begin
      r_fault_latched <= 1'b1;
    end else if (fault_clr) begin
      r_fault_latched <= 1'b0;
    end
  end

  // Raw fault_in is included so the gates drop at the same edge that
  // first sees the fault, not one cycle later via the latch.
  assign w_kill = !enable || r_fault_latched || fault_in;

  for (genvar g = 0; g < PHASES; g++) begin : g_leg
    pwm_deadtime_phase #(
      .DT_WIDTH(DT_WIDTH)
    ) u_leg (
      .clk        (clk),
      .rst        (rst),
      .pwm        (pwm_in[g]),
      .dead_cycles(dead_cycles),
      .kill       (w_kill),
      .gate_hi    (gate_hi[g]),
      .gate_lo    (gate_lo[g])
    );
  end

  assign fault_latched = r_fault_latched;

endmodule
